// File: rtl/dmi_dtm_ctrl_pkg.sv
// Shared types for the JTAG DTM DMI transaction controller.
package dmi_dtm_ctrl_pkg;

    // Op field of the DMI data register.
    typedef enum logic [1:0] {
        DtmNop   = 2'd0,
        DtmRead  = 2'd1,
        DtmWrite = 2'd2
    } dtm_op_e;

    // Sticky error reported through dtmcs.dmistat and the DR op field.
    typedef enum logic [1:0] {
        DmiNoError  = 2'd0,
        DmiOpFailed = 2'd2,
        DmiBusy     = 2'd3
    } dmi_error_e;

    // Transaction controller states.
    typedef enum logic [2:0] {
        StIdle      = 3'd0,
        StRead      = 3'd1,
        StWaitRead  = 3'd2,
        StWrite     = 3'd3,
        StWaitWrite = 3'd4
    } dtm_state_e;

    // Status captured into the DR op field: a busy event in the capture
    // cycle is reported even before it lands in the sticky error register.
    function automatic logic [1:0] capture_status(input logic busy, input logic [1:0] err);
        logic [1:0] status;
        if (busy) begin
            status = DmiBusy;
        end else begin
            status = err;
        end
        return status;
    endfunction

endpackage

// File: rtl/dmi_dtm_ctrl_if.sv
// DMI request/response channel between the DTM and the CDC towards the DM.
interface dmi_dtm_ctrl_if #(
    parameter int AbitsWidth = 7,
    parameter int DataWidth  = 32
);
    logic [AbitsWidth-1:0] req_addr;
    logic [DataWidth-1:0]  req_data;
    logic [1:0]            req_op;
    logic                  req_valid;
    logic                  req_ready;
    logic [DataWidth-1:0]  resp_data;
    logic [1:0]            resp_op;
    logic                  resp_valid;
    logic                  resp_ready;

    modport master (
        output req_addr, req_data, req_op, req_valid, resp_ready,
        input  req_ready, resp_data, resp_op, resp_valid
    );

    modport slave (
        input  req_addr, req_data, req_op, req_valid, resp_ready,
        output req_ready, resp_data, resp_op, resp_valid
    );
endinterface

// File: rtl/dmi_dtm_ctrl_counters.sv
// Response-wait counter with terminal-count flag and saturating busy-event counter.
module dmi_dtm_ctrl_counters #(
    parameter int TimeoutCycles = 1024,
    parameter int BusyCntWidth  = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wait_en,
    input  logic                    wait_clr,
    output logic                    wait_done,
    input  logic                    busy_evt,
    input  logic                    busy_clr,
    output logic [BusyCntWidth-1:0] busy_cnt
);
    localparam int CntW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
    localparam logic [CntW-1:0] LastCnt = (TimeoutCycles > 0) ? CntW'(TimeoutCycles - 1) : '0;
    localparam bit TimeoutOn = (TimeoutCycles > 0);

    logic [CntW-1:0]         wait_cnt_r;
    logic [BusyCntWidth-1:0] busy_cnt_r;

    // A timeout of 0 keeps the flag permanently low.
    assign wait_done = TimeoutOn && wait_en && (wait_cnt_r == LastCnt);
    assign busy_cnt  = busy_cnt_r;

    // Count cycles spent waiting for a response; any non-waiting cycle clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_r <= '0;
        end else if (wait_clr || !wait_en) begin
            wait_cnt_r <= '0;
        end else if (wait_cnt_r != LastCnt) begin
            wait_cnt_r <= wait_cnt_r + CntW'(1);
        end else begin
            wait_cnt_r <= wait_cnt_r;
        end
    end

    // Busy events saturate at all-ones rather than wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_cnt_r <= '0;
        end else if (busy_clr) begin
            busy_cnt_r <= '0;
        end else if (busy_evt && (busy_cnt_r != {BusyCntWidth{1'b1}})) begin
            busy_cnt_r <= busy_cnt_r + BusyCntWidth'(1);
        end else begin
            busy_cnt_r <= busy_cnt_r;
        end
    end
endmodule

// File: rtl/dmi_dtm_ctrl.sv
// DMI transaction controller for the JTAG DTM, entirely in the TCK domain.
module dmi_dtm_ctrl
    import dmi_dtm_ctrl_pkg::*;
#(
    parameter int AbitsWidth    = 7,
    parameter int DataWidth     = 32,
    parameter int TimeoutCycles = 1024,
    parameter int BusyCntWidth  = 8
) (
    input  logic                    tck_i,
    input  logic                    trst_ni,
    input  logic                    test_logic_reset_i,
    input  logic                    capture_dr_i,
    input  logic                    shift_dr_i,
    input  logic                    update_dr_i,
    input  logic                    dmi_access_i,
    input  logic                    dtmcs_select_i,
    input  logic                    dmi_reset_i,
    input  logic                    dmi_hard_reset_i,
    input  logic                    dmi_tdi_i,
    output logic                    dmi_tdo_o,
    output logic [1:0]              dmi_error_o,
    output logic                    timeout_o,
    output logic [BusyCntWidth-1:0] busy_cnt_o,
    dmi_dtm_ctrl_if.master          dmi
);
    localparam int DrWidth = AbitsWidth + DataWidth + 2;

    dtm_state_e            state_r;
    logic [DrWidth-1:0]    dr_r;
    logic [AbitsWidth-1:0] addr_r;
    logic [DataWidth-1:0]  data_r;
    logic [1:0]            error_r;
    logic                  req_valid_r;
    logic [1:0]            req_op_r;
    logic                  timeout_r;

    logic                  upd_s, cap_s, shift_s, hard_s, clr_s;
    logic                  in_wait_s, busy_evt_s, resp_fail_s, timeout_hit_s, wait_done_s;
    logic [1:0]            err_new_s;
    logic [AbitsWidth-1:0] dr_addr_s;
    logic [DataWidth-1:0]  dr_data_s;
    logic [1:0]            dr_op_s;

    assign upd_s     = update_dr_i & dmi_access_i;
    assign cap_s     = capture_dr_i & dmi_access_i;
    assign shift_s   = shift_dr_i & dmi_access_i;
    assign hard_s    = dmi_hard_reset_i & dtmcs_select_i;
    assign clr_s     = dmi_reset_i & dtmcs_select_i;
    assign in_wait_s = (state_r == StWaitRead) || (state_r == StWaitWrite);

    assign busy_evt_s    = (upd_s && (state_r != StIdle)) ||
                           (cap_s && ((state_r == StRead) || (state_r == StWaitRead)));
    assign resp_fail_s   = in_wait_s && dmi.resp_valid && (dmi.resp_op != 2'd0);
    assign timeout_hit_s = wait_done_s && !dmi.resp_valid;

    assign dr_addr_s = dr_r[DrWidth-1 -: AbitsWidth];
    assign dr_data_s = dr_r[DataWidth+1:2];
    assign dr_op_s   = dr_r[1:0];

    assign dmi_tdo_o   = dr_r[0];
    assign dmi_error_o = error_r;
    assign timeout_o   = timeout_r;

    assign dmi.req_addr   = addr_r;
    assign dmi.req_data   = data_r;
    assign dmi.req_op     = req_op_r;
    // An abort removes the request in the same cycle, before the state register follows.
    assign dmi.req_valid  = req_valid_r & ~hard_s;
    assign dmi.resp_ready = 1'b1;

    dmi_dtm_ctrl_counters #(
        .TimeoutCycles (TimeoutCycles),
        .BusyCntWidth  (BusyCntWidth)
    ) u_counters (
        .clk       (tck_i),
        .rst_n     (trst_ni),
        .wait_en   (in_wait_s),
        .wait_clr  (hard_s),
        .wait_done (wait_done_s),
        .busy_evt  (busy_evt_s),
        .busy_clr  (hard_s),
        .busy_cnt  (busy_cnt_o)
    );

    // Pick the error raised this cycle; busy outranks op-failed.
    always_comb begin
        err_new_s = DmiNoError;
        if (busy_evt_s) begin
            err_new_s = DmiBusy;
        end else if (resp_fail_s || timeout_hit_s) begin
            err_new_s = DmiOpFailed;
        end else begin
            err_new_s = DmiNoError;
        end
    end

    // Sticky error: first error wins, clears win over new errors.
    always_ff @(posedge tck_i or negedge trst_ni) begin
        if (!trst_ni) begin
            error_r <= DmiNoError;
        end else if (hard_s || clr_s) begin
            error_r <= DmiNoError;
        end else if (error_r == DmiNoError) begin
            error_r <= err_new_s;
        end else begin
            error_r <= error_r;
        end
    end

    // DMI data register: TAP reset, capture of the last result, then shift.
    always_ff @(posedge tck_i or negedge trst_ni) begin
        if (!trst_ni) begin
            dr_r <= '0;
        end else if (test_logic_reset_i) begin
            dr_r <= '0;
        end else if (cap_s) begin
            dr_r <= {addr_r, data_r, capture_status(busy_evt_s, error_r)};
        end else if (shift_s) begin
            dr_r <= {dmi_tdi_i, dr_r[DrWidth-1:1]};
        end else begin
            dr_r <= dr_r;
        end
    end

    // Transaction FSM with registered request and timeout outputs.
    always_ff @(posedge tck_i or negedge trst_ni) begin
        if (!trst_ni) begin
            state_r     <= StIdle;
            addr_r      <= '0;
            data_r      <= '0;
            req_valid_r <= 1'b0;
            req_op_r    <= DtmRead;
            timeout_r   <= 1'b0;
        end else if (hard_s) begin
            state_r     <= StIdle;
            req_valid_r <= 1'b0;
            req_op_r    <= DtmRead;
            timeout_r   <= 1'b0;
        end else begin
            timeout_r <= 1'b0;
            case (state_r)
                StIdle: begin
                    if (upd_s && (error_r == DmiNoError)) begin
                        addr_r <= dr_addr_s;
                        data_r <= dr_data_s;
                        case (dr_op_s)
                            DtmRead: begin
                                state_r     <= StRead;
                                req_valid_r <= 1'b1;
                                req_op_r    <= DtmRead;
                            end
                            DtmWrite: begin
                                state_r     <= StWrite;
                                req_valid_r <= 1'b1;
                                req_op_r    <= DtmWrite;
                            end
                            default: state_r <= StIdle;
                        endcase
                    end
                end
                StRead: begin
                    if (dmi.req_ready) begin
                        state_r     <= StWaitRead;
                        req_valid_r <= 1'b0;
                    end
                end
                StWrite: begin
                    if (dmi.req_ready) begin
                        state_r     <= StWaitWrite;
                        req_valid_r <= 1'b0;
                        req_op_r    <= DtmRead;
                    end
                end
                StWaitRead: begin
                    if (dmi.resp_valid) begin
                        if (dmi.resp_op == 2'd0) begin
                            data_r <= dmi.resp_data;
                        end
                        state_r <= StIdle;
                    end else if (wait_done_s) begin
                        state_r   <= StIdle;
                        timeout_r <= 1'b1;
                    end
                end
                StWaitWrite: begin
                    if (dmi.resp_valid) begin
                        state_r <= StIdle;
                    end else if (wait_done_s) begin
                        state_r   <= StIdle;
                        timeout_r <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= StIdle;
                    req_valid_r <= 1'b0;
                    req_op_r    <= DtmRead;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dmi_dtm_ctrl.sv
// Directed self-checking bench: DUT A (7/32, timeout 8) and DUT B (10/64, 2-bit busy counter).
module tb_dmi_dtm_ctrl;

    logic tck = 1'b0;
    logic trst_n;
    always #5 tck = ~tck;

    logic [1:0] tlr_s, cap_s, shf_s, upd_s, acc_s, sel_s, dres_s, dhard_s, tdi_s;
    logic [1:0] req_ready_s, resp_valid_s, resp_op_a, resp_op_b;
    logic [31:0] resp_data_a;
    logic [63:0] resp_data_b;

    logic       tdo_a, tdo_b, tmo_a, tmo_b;
    logic [1:0] err_a, err_b;
    logic [7:0] bcnt_a;
    logic [1:0] bcnt_b;

    int n_checks = 0;
    int n_fail   = 0;

    dmi_dtm_ctrl_if #(.AbitsWidth(7),  .DataWidth(32)) if_a ();
    dmi_dtm_ctrl_if #(.AbitsWidth(10), .DataWidth(64)) if_b ();

    assign if_a.req_ready  = req_ready_s[0];
    assign if_a.resp_valid = resp_valid_s[0];
    assign if_a.resp_op    = resp_op_a;
    assign if_a.resp_data  = resp_data_a;
    assign if_b.req_ready  = req_ready_s[1];
    assign if_b.resp_valid = resp_valid_s[1];
    assign if_b.resp_op    = resp_op_b;
    assign if_b.resp_data  = resp_data_b;

    dmi_dtm_ctrl #(.AbitsWidth(7), .DataWidth(32), .TimeoutCycles(8), .BusyCntWidth(8)) dut_a (
        .tck_i(tck), .trst_ni(trst_n), .test_logic_reset_i(tlr_s[0]),
        .capture_dr_i(cap_s[0]), .shift_dr_i(shf_s[0]), .update_dr_i(upd_s[0]),
        .dmi_access_i(acc_s[0]), .dtmcs_select_i(sel_s[0]), .dmi_reset_i(dres_s[0]),
        .dmi_hard_reset_i(dhard_s[0]), .dmi_tdi_i(tdi_s[0]), .dmi_tdo_o(tdo_a),
        .dmi_error_o(err_a), .timeout_o(tmo_a), .busy_cnt_o(bcnt_a), .dmi(if_a)
    );

    dmi_dtm_ctrl #(.AbitsWidth(10), .DataWidth(64), .TimeoutCycles(8), .BusyCntWidth(2)) dut_b (
        .tck_i(tck), .trst_ni(trst_n), .test_logic_reset_i(tlr_s[1]),
        .capture_dr_i(cap_s[1]), .shift_dr_i(shf_s[1]), .update_dr_i(upd_s[1]),
        .dmi_access_i(acc_s[1]), .dtmcs_select_i(sel_s[1]), .dmi_reset_i(dres_s[1]),
        .dmi_hard_reset_i(dhard_s[1]), .dmi_tdi_i(tdi_s[1]), .dmi_tdo_o(tdo_b),
        .dmi_error_o(err_b), .timeout_o(tmo_b), .busy_cnt_o(bcnt_b), .dmi(if_b)
    );

    typedef struct {
        logic [6:0]  addr;
        logic [31:0] data;
        logic [1:0]  op;
        logic [1:0]  rsp_op;
        logic [31:0] rsp_data;
        logic        exp_req;
        logic [31:0] exp_data;
        logic [1:0]  exp_err;
    } vec_t;

    vec_t vecs [7];

    function automatic int dr_width(int d);
        return (d == 0) ? 41 : 76;
    endfunction

    function automatic logic [127:0] pack(int d, logic [9:0] a, logic [63:0] dt, logic [1:0] op);
        if (d == 0) return {87'd0, a[6:0], dt[31:0], op};
        else        return {52'd0, a, dt, op};
    endfunction

    function automatic logic get_tdo(int d);         return (d == 0) ? tdo_a : tdo_b; endfunction
    function automatic logic [1:0] get_err(int d);   return (d == 0) ? err_a : err_b; endfunction
    function automatic logic [7:0] get_bcnt(int d);  return (d == 0) ? bcnt_a : {6'd0, bcnt_b}; endfunction
    function automatic logic get_rv(int d);          return (d == 0) ? if_a.req_valid : if_b.req_valid; endfunction
    function automatic logic [1:0] get_rop(int d);   return (d == 0) ? if_a.req_op : if_b.req_op; endfunction
    function automatic logic [9:0] get_raddr(int d); return (d == 0) ? {3'd0, if_a.req_addr} : if_b.req_addr; endfunction
    function automatic logic [63:0] get_rdata(int d); return (d == 0) ? {32'd0, if_a.req_data} : if_b.req_data; endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge tck);
        #1;
    endtask

    task automatic update(input int d);
        upd_s[d] = 1'b1; step(); upd_s[d] = 1'b0;
    endtask

    task automatic shift(input int d, input logic [127:0] din, output logic [127:0] dout);
        dout = '0;
        shf_s[d] = 1'b1;
        for (int i = 0; i < dr_width(d); i++) begin
            dout[i]  = get_tdo(d);
            tdi_s[d] = din[i];
            step();
        end
        shf_s[d] = 1'b0;
        tdi_s[d] = 1'b0;
    endtask

    task automatic issue(input int d, input logic [9:0] a, input logic [63:0] dt, input logic [1:0] op);
        logic [127:0] junk;
        shift(d, pack(d, a, dt, op), junk);
        update(d);
    endtask

    task automatic readback(input int d, output logic [127:0] val);
        cap_s[d] = 1'b1; step(); cap_s[d] = 1'b0;
        shift(d, 128'd0, val);
    endtask

    task automatic handshake(input int d);
        req_ready_s[d] = 1'b1; step(); req_ready_s[d] = 1'b0;
    endtask

    task automatic respond(input int d, input logic [1:0] op, input logic [63:0] dt);
        resp_valid_s[d] = 1'b1;
        if (d == 0) begin resp_op_a = op; resp_data_a = dt[31:0]; end
        else        begin resp_op_b = op; resp_data_b = dt; end
        step();
        resp_valid_s[d] = 1'b0;
    endtask

    task automatic dmireset(input int d);
        dres_s[d] = 1'b1; step(); dres_s[d] = 1'b0;
    endtask

    task automatic hardreset(input int d);
        dhard_s[d] = 1'b1; step(); dhard_s[d] = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: actual still running, required finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [127:0] rb;
        tlr_s = '0; cap_s = '0; shf_s = '0; upd_s = '0; dres_s = '0; dhard_s = '0; tdi_s = '0;
        acc_s = 2'b11; sel_s = 2'b11;
        req_ready_s = '0; resp_valid_s = '0; resp_op_a = '0; resp_op_b = '0;
        resp_data_a = '0; resp_data_b = '0;

        vecs[0] = '{7'h11, 32'h00000000, 2'd1, 2'd0, 32'hDEADBEEF, 1'b1, 32'hDEADBEEF, 2'd0};
        vecs[1] = '{7'h04, 32'h12345678, 2'd2, 2'd2, 32'hFFFFFFFF, 1'b1, 32'h12345678, 2'd2};
        vecs[2] = '{7'h22, 32'hCAFEF00D, 2'd2, 2'd0, 32'h00000000, 1'b1, 32'hCAFEF00D, 2'd0};
        vecs[3] = '{7'h7F, 32'h0BADF00D, 2'd1, 2'd1, 32'h13572468, 1'b1, 32'h0BADF00D, 2'd2};
        vecs[4] = '{7'h33, 32'h55AA55AA, 2'd0, 2'd0, 32'h00000000, 1'b0, 32'h55AA55AA, 2'd0};
        vecs[5] = '{7'h00, 32'hFFFFFFFF, 2'd3, 2'd0, 32'h00000000, 1'b0, 32'hFFFFFFFF, 2'd0};
        vecs[6] = '{7'h5A, 32'h00000000, 2'd1, 2'd0, 32'h80000001, 1'b1, 32'h80000001, 2'd0};

        // Reset values.
        trst_n = 1'b0;
        #23;
        check("rst_tdo",        tdo_a, 1'b0);
        check("rst_err",        err_a, 2'd0);
        check("rst_req_valid",  if_a.req_valid, 1'b0);
        check("rst_req_op",     if_a.req_op, 2'd1);
        check("rst_timeout",    tmo_a, 1'b0);
        check("rst_resp_ready", if_a.resp_ready, 1'b1);
        check("rst_busy_cnt",   bcnt_a, 8'd0);
        check("rst_b_busy_cnt", bcnt_b, 2'd0);
        trst_n = 1'b1;
        step();
        readback(0, rb);
        check("rst_capture", rb, 128'd0);

        // Shift direction, then Test-Logic-Reset beating a simultaneous shift.
        begin
            logic [127:0] junk;
            shift(0, 128'h0ABCDEF0123, junk);
            shift(0, 128'd0, rb);
            check("shift_roundtrip", rb, 128'h0ABCDEF0123);
            shift(0, 128'h0ABCDEF0123, junk);
            tlr_s[0] = 1'b1; shf_s[0] = 1'b1; tdi_s[0] = 1'b1; step();
            tlr_s[0] = 1'b0; shf_s[0] = 1'b0; tdi_s[0] = 1'b0;
            shift(0, 128'd0, rb);
            check("tlr_clears_dr", rb, 128'd0);
        end

        // Table of single transactions on DUT A.
        for (int v = 0; v < 7; v++) begin
            dmireset(0);
            issue(0, {3'd0, vecs[v].addr}, {32'd0, vecs[v].data}, vecs[v].op);
            check($sformatf("vec%0d_req_valid", v), get_rv(0), vecs[v].exp_req);
            if (vecs[v].exp_req) begin
                check($sformatf("vec%0d_req_op", v),   get_rop(0),   vecs[v].op);
                check($sformatf("vec%0d_req_addr", v), get_raddr(0), vecs[v].addr);
                check($sformatf("vec%0d_req_data", v), get_rdata(0), vecs[v].data);
                handshake(0);
                check($sformatf("vec%0d_req_drop", v), get_rv(0), 1'b0);
                respond(0, vecs[v].rsp_op, {32'd0, vecs[v].rsp_data});
            end
            check($sformatf("vec%0d_err", v), get_err(0), vecs[v].exp_err);
            readback(0, rb);
            check($sformatf("vec%0d_capture", v), rb,
                  pack(0, {3'd0, vecs[v].addr}, {32'd0, vecs[v].exp_data}, vecs[v].exp_err));
        end

        // Failed write blocks further updates until dmireset.
        issue(0, 10'h04, 64'h12345678, 2'd2);
        handshake(0);
        respond(0, 2'd2, 64'd0);
        check("wfail_err", err_a, 2'd2);
        issue(0, 10'h05, 64'hAAAAAAAA, 2'd2);
        check("wfail_blocked", if_a.req_valid, 1'b0);
        check("wfail_err_sticky", err_a, 2'd2);
        dmireset(0);
        check("wfail_cleared", err_a, 2'd0);
        issue(0, 10'h05, 64'hAAAAAAAA, 2'd2);
        check("wfail_resume_valid", if_a.req_valid, 1'b1);
        check("wfail_resume_op", if_a.req_op, 2'd2);
        handshake(0);
        respond(0, 2'd0, 64'd0);
        check("wfail_resume_err", err_a, 2'd0);

        // Busy: second update while the read is still waiting for req_ready.
        issue(0, 10'h10, 64'd0, 2'd1);
        issue(0, 10'h20, 64'h99, 2'd1);
        check("busy_err", err_a, 2'd3);
        check("busy_cnt1", bcnt_a, 8'd1);
        check("busy_req_held", if_a.req_valid, 1'b1);
        check("busy_addr_held", if_a.req_addr, 7'h10);
        readback(0, rb);
        check("busy_capture", rb, pack(0, 10'h10, 64'd0, 2'd3));
        check("busy_cnt2", bcnt_a, 8'd2);
        dmireset(0);
        check("busy_cleared", err_a, 2'd0);
        handshake(0);
        respond(0, 2'd0, 64'h600DF00D);
        readback(0, rb);
        check("busy_finish", rb, pack(0, 10'h10, 64'h600DF00D, 2'd0));

        // Hard reset from WaitWrite with five busy events recorded.
        issue(0, 10'h44, 64'h01020304, 2'd2);
        handshake(0);
        for (int k = 0; k < 3; k++) update(0);
        check("hard_pre_busy", bcnt_a, 8'd5);
        check("hard_pre_err", err_a, 2'd3);
        hardreset(0);
        check("hard_err", err_a, 2'd0);
        check("hard_busy", bcnt_a, 8'd0);
        check("hard_req_valid", if_a.req_valid, 1'b0);
        respond(0, 2'd2, 64'd0);
        check("hard_late_resp", err_a, 2'd0);
        issue(0, 10'h45, 64'd0, 2'd1);
        check("hard_new_valid", if_a.req_valid, 1'b1);
        check("hard_new_op", if_a.req_op, 2'd1);
        handshake(0);
        respond(0, 2'd0, 64'hA5A5A5A5);
        readback(0, rb);
        check("hard_new_capture", rb, pack(0, 10'h45, 64'hA5A5A5A5, 2'd0));

        // Hard reset in Read removes req_valid in the same cycle.
        issue(0, 10'h46, 64'd0, 2'd1);
        dhard_s[0] = 1'b1;
        #1;
        check("hard_comb_drop", if_a.req_valid, 1'b0);
        step();
        dhard_s[0] = 1'b0;
        check("hard_read_idle", if_a.req_valid, 1'b0);

        // Timeout after eight WaitRead cycles.
        issue(0, 10'h12, 64'h77, 2'd1);
        handshake(0);
        for (int c = 1; c < 8; c++) begin
            step();
            check($sformatf("tmo_quiet%0d", c), tmo_a, 1'b0);
        end
        step();
        check("tmo_pulse", tmo_a, 1'b1);
        check("tmo_err", err_a, 2'd2);
        check("tmo_req_valid", if_a.req_valid, 1'b0);
        step();
        check("tmo_pulse_end", tmo_a, 1'b0);
        respond(0, 2'd0, 64'h11111111);
        check("tmo_late_err", err_a, 2'd2);
        dmireset(0);
        readback(0, rb);
        check("tmo_late_discard", rb, pack(0, 10'h12, 64'h77, 2'd0));

        // Response on the final count beats the timeout.
        issue(0, 10'h13, 64'd0, 2'd1);
        handshake(0);
        repeat (7) step();
        respond(0, 2'd0, 64'h2468ACE0);
        check("race_timeout", tmo_a, 1'b0);
        check("race_err", err_a, 2'd0);
        readback(0, rb);
        check("race_capture", rb, pack(0, 10'h13, 64'h2468ACE0, 2'd0));

        // Wide configuration round trips on DUT B.
        issue(1, 10'h3FF, 64'h0123456789ABCDEF, 2'd2);
        check("b_req_valid", if_b.req_valid, 1'b1);
        check("b_req_addr", if_b.req_addr, 10'h3FF);
        check("b_req_data", if_b.req_data, 64'h0123456789ABCDEF);
        handshake(1);
        respond(1, 2'd0, 64'd0);
        readback(1, rb);
        check("b_write_capture", rb, pack(1, 10'h3FF, 64'h0123456789ABCDEF, 2'd0));
        issue(1, 10'h2A5, 64'd0, 2'd1);
        handshake(1);
        respond(1, 2'd0, 64'hFEDCBA9876543210);
        readback(1, rb);
        check("b_read_capture", rb, pack(1, 10'h2A5, 64'hFEDCBA9876543210, 2'd0));

        // 2-bit busy counter saturates at 3.
        issue(1, 10'h001, 64'd0, 2'd1);
        for (int k = 1; k <= 4; k++) begin
            update(1);
            check($sformatf("b_sat%0d", k), bcnt_b, (k > 3) ? 2'd3 : 2'(k));
        end
        check("b_busy_err", err_b, 2'd3);
        hardreset(1);
        check("b_hard_busy", bcnt_b, 2'd0);
        check("b_hard_err", err_b, 2'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
